// File: rtl/bus_tx_framer_pkg.sv
// Shared bus IDs, header field layout and framer state encoding.
package bus_tx_framer_pkg;

  localparam logic [1:0] ID_AES  = 2'b00;
  localparam logic [1:0] ID_SHA  = 2'b01;
  localparam logic [1:0] ID_MEM  = 2'b10;
  localparam logic [1:0] ID_CTRL = 2'b11;

  localparam int HDR_SRC_LSB  = 2;
  localparam int HDR_DEST_LSB = 4;
  localparam int HDR_OP_LSB   = 6;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_WAIT,
    TX_HDR,
    TX_PAY,
    TX_CSUM,
    TX_END
  } tx_state_t;

  function automatic logic [7:0] make_hdr(input logic [1:0] op, input logic [1:0] dest,
                                          input logic [1:0] src);
    logic [7:0] h;
    h = '0;
    h[HDR_OP_LSB +: 2]   = op;
    h[HDR_DEST_LSB +: 2] = dest;
    h[HDR_SRC_LSB +: 2]  = src;
    return h;
  endfunction

endpackage

// File: rtl/bus_tx_framer_if.sv
// Byte-wide send channel between a framer (master) and the shared-bus interface (slave).
interface bus_tx_framer_if;
  logic       send_valid;
  logic [7:0] send_data;
  logic       send_ready;
  logic       ack;

  modport master (output send_valid, output send_data, output ack, input send_ready);
  modport slave  (input send_valid, input send_data, input ack, output send_ready);
endinterface

// File: rtl/bus_tx_framer_byte_fifo.sv
// Byte FIFO, registered count; full reflects the count at the clock edge, so a
// same-cycle pop never frees a slot for a push.
module byte_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bus_tx_framer.sv
// Transaction framer: buffers payload, then sends header, payload, optional XOR
// checksum (TX_CHECKSUM_EN) and a one-cycle ack onto the shared-bus send channel.
module bus_tx_framer
  import bus_tx_framer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       src_id,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_dest,
  input  logic [1:0]       req_op,
  input  logic [LEN_W-1:0] req_len,
  input  logic             wr_valid,
  input  logic [7:0]       wr_data,
  output logic             wr_ready,
  bus_tx_framer_if.master  tx,
  output logic             busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DEPTH);
`ifdef TX_CHECKSUM_EN
  localparam tx_state_t ST_TAIL = TX_CSUM;
`else
  localparam tx_state_t ST_TAIL = TX_END;
`endif

  tx_state_t        state;
  tx_state_t        state_nxt;
  logic [1:0]       dest_q;
  logic [1:0]       op_q;
  logic [CW-1:0]    len_q;
  logic [CW-1:0]    rem_q;
  logic [LEN_W-1:0] len_clamped;
  logic [7:0]       hdr;
  logic             xfer;
  logic             fifo_pop;
  logic [7:0]       fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
`ifdef TX_CHECKSUM_EN
  logic [7:0]       csum_q;
`endif

  assign len_clamped = (req_len > LEN_MAX) ? LEN_MAX : req_len;
  assign hdr         = make_hdr(op_q, dest_q, src_id);
  assign xfer        = tx.send_valid && tx.send_ready;
  assign wr_ready    = !fifo_full;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_valid),
    .din   (wr_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= TX_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      TX_IDLE: if (req_valid) state_nxt = TX_WAIT;
      TX_WAIT: if (fifo_count >= len_q) state_nxt = TX_HDR;
      TX_HDR:  if (xfer) state_nxt = (len_q != '0) ? TX_PAY : ST_TAIL;
      TX_PAY:  if (xfer && rem_q == CW'(1)) state_nxt = ST_TAIL;
      TX_CSUM: if (xfer) state_nxt = TX_END;
      TX_END:  state_nxt = TX_IDLE;
      default: state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (state == TX_IDLE);
    busy          = (state != TX_IDLE);
    tx.send_valid = 1'b0;
    tx.send_data  = 8'h00;
    tx.ack        = 1'b0;
    fifo_pop      = 1'b0;
    case (state)
      TX_HDR: begin
        tx.send_valid = 1'b1;
        tx.send_data  = hdr;
      end
      TX_PAY: begin
        tx.send_valid = 1'b1;
        tx.send_data  = fifo_dout;
        fifo_pop      = tx.send_ready && !fifo_empty;
      end
`ifdef TX_CHECKSUM_EN
      TX_CSUM: begin
        tx.send_valid = 1'b1;
        tx.send_data  = csum_q;
      end
`endif
      TX_END:  tx.ack = 1'b1;
      default: ;
    endcase
  end

  // Request fields are held for the whole transaction; rem_q counts payload bytes left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dest_q <= '0;
      op_q   <= '0;
      len_q  <= '0;
      rem_q  <= '0;
`ifdef TX_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      if (state == TX_IDLE && req_valid) begin
        dest_q <= req_dest;
        op_q   <= req_op;
        len_q  <= CW'(len_clamped);
      end
      if (state == TX_HDR && xfer) rem_q <= len_q;
      if (state == TX_PAY && xfer) rem_q <= rem_q - CW'(1);
`ifdef TX_CHECKSUM_EN
      if (state == TX_HDR && xfer) csum_q <= hdr;
      if (state == TX_PAY && xfer) csum_q <= csum_q ^ fifo_dout;
`endif
    end
  end

endmodule
